tick_gen: RTL and testbench

Time-base and run-control stage that sits directly upstream of the decade counter chain in the century clock. It divides the board clock into single-cycle `tick` pulses, which drive the `enable` input of the least-significant digit counter. It also debounces the front-panel RUN button (and optionally a STEP button) to start, pause or single-step the clock. A FAST input selects a shorter period for demos and bring-up.

---
 rtl/tick_gen.sv | 173 +++++++++++++++++
 tb/tb_tick_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tick_gen
//   Time base and run control for the century clock. The board clock is divided
//   into single-cycle tick pulses that enable the least-significant digit
//   counter. A debounced RUN button toggles between PAUSED and RUN. With
//   TICK_STEP_EN defined, a debounced STEP button issues one tick while paused.
//
//   Optional feature macro: TICK_STEP_EN (adds btn_step and its debouncer).
//
//   Parameters
//     DIV        clk cycles per tick in normal mode (>= 2)
//     FAST_DIV   clk cycles per tick when fast=1 (2 <= FAST_DIV <= DIV)
//     DB_CYCLES  consecutive stable cycles to accept a button change (>= 1)
//
//   Ports
//     clk       in   system clock
//     reset_n   in   asynchronous active-low reset
//     btn_run   in   raw RUN button, active-high, asynchronous
//     btn_step  in   raw STEP button (TICK_STEP_EN only)
//     fast      in   synchronous level selecting the FAST_DIV period
//     tick      out  registered one-cycle tick pulse
//     running   out  registered, high while in RUN
// -----------------------------------------------------------------------------

// Button conditioner: 2-flop synchronizer, debouncer, registered press pulse.
module tick_gen_db #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic press_o
);
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  // Counter value in the cycle that makes the DB_CYCLES-th stable sample.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic            db_dly_q;
  logic            press_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      db_dly_q <= db_q;
      // Rising edge of the debounced level only; releases are ignored.
      press_q  <= db_q & ~db_dly_q;
    end
  end

  assign press_o = press_q;
endmodule

module tick_gen #(
  parameter int DIV       = 50_000_000,
  parameter int FAST_DIV  = 500_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_run,
`ifdef TICK_STEP_EN
  input  logic btn_step,
`endif
  input  logic fast,
  output logic tick,
  output logic running
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM_SLOW = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] TERM_FAST = CNT_W'(FAST_DIV - 1);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term;
  logic             tick_d;
  logic             run_press;
  logic             step_press;

  tick_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_i   (btn_run),
    .press_o (run_press)
  );

`ifdef TICK_STEP_EN
  tick_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_i   (btn_step),
    .press_o (step_press)
  );
`else
  assign step_press = 1'b0;
`endif

  assign term = fast ? TERM_FAST : TERM_SLOW;

  // Using >= rather than == means that raising fast while cnt is already
  // past the short terminal value fires one tick immediately instead of
  // wrapping through the long period.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (state_q == RUN) begin
      if (cnt_q >= term) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // RUN press wins over a simultaneous STEP press.
      tick_d = step_press & ~run_press;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAUSED;
      running <= 1'b0;
      tick    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= tick_d;
      case (state_q)
        RUN: begin
          if (run_press) begin
            state_q <= PAUSED;
            running <= 1'b0;
          end
        end
        default: begin
          if (run_press) begin
            state_q <= RUN;
            running <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tick_gen.sv
`timescale 1ns/1ps
module tb_tick_gen;
  localparam int DIV       = 10;
  localparam int FAST_DIV  = 4;
  localparam int DB_CYCLES = 3;
`ifdef TICK_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic btn_run;
  logic btn_step;
  logic fast;
  logic tick;
  logic running;

  int n_checks = 0;
  int n_fail   = 0;

  tick_gen #(.DIV(DIV), .FAST_DIV(FAST_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_run (btn_run),
`ifdef TICK_STEP_EN
    .btn_step(btn_step),
`endif
    .fast    (fast),
    .tick    (tick),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, one entry per button (0 = RUN, 1 = STEP).
  // A button's debounced level adopts the synchronized value once that value
  // has been seen for DB_CYCLES consecutive cycles while differing from it.
  logic m_s1[2], m_s2[2], m_last[2], m_db[2], m_rose[2], m_press[2];
  int   m_len[2];
  logic m_run, m_tick;
  int   m_phase;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_last[b] = 0; m_db[b] = 0;
      m_rose[b] = 0; m_press[b] = 0; m_len[b] = 0;
    end
    m_run = 0; m_tick = 0; m_phase = 0;
  endtask

  task automatic model_step();
    logic raw[2];
    logic old_press[2];
    logic new_db;
    int   term;
    raw[0] = btn_run;
    raw[1] = STEP_EN ? btn_step : 1'b0;
    old_press[0] = m_press[0];
    old_press[1] = m_press[1];
    for (int b = 0; b < 2; b++) begin
      if (m_s2[b] == m_last[b]) begin
        if (m_len[b] < 1_000_000) m_len[b]++;
      end else begin
        m_len[b] = 1;
      end
      m_last[b] = m_s2[b];
      new_db = m_db[b];
      if (m_s2[b] != m_db[b] && m_len[b] == DB_CYCLES) new_db = m_s2[b];
      m_press[b] = m_rose[b];
      m_rose[b]  = new_db & ~m_db[b];
      m_db[b]    = new_db;
      m_s2[b]    = m_s1[b];
      m_s1[b]    = raw[b];
    end
    if (m_run) begin
      term = fast ? FAST_DIV - 1 : DIV - 1;
      if (m_phase >= term) begin
        m_phase = 0;
        m_tick  = 1;
      end else begin
        m_phase++;
        m_tick = 0;
      end
    end else begin
      m_phase = 0;
      m_tick  = old_press[1] & ~old_press[0];
    end
    if (old_press[0]) m_run = ~m_run;
  endtask

  // One clock: advance the model at the edge, compare just after it, and
  // return on the falling edge so the caller can change inputs.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("tick", tick, m_tick);
    chk("running", running, m_run);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_run(input int hold);
    btn_run = 1;
    cycles(hold);
    btn_run = 0;
    cycles(8);
  endtask

  initial begin
    int rise_at, tick_at, cnt_ticks, dur;
    logic got_tick;
    reset_n = 1; btn_run = 0; btn_step = 0; fast = 0;
    #2 reset_n = 0;
    #1;
    chk("reset_tick", tick, 0);
    chk("reset_running", running, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1;

    // Idle: no buttons, random fast level.
    for (int i = 0; i < 200; i++) begin
      fast = 1'($urandom_range(0, 1));
      cycle();
    end
    fast = 0;

    // Glitch shorter than the debounce window.
    btn_run = 1;
    cycles(2);
    btn_run = 0;
    cycles(10);
    chk("glitch_running", running, 0);

    // Press held 20 cycles: running from cycle 6, first tick at cycle 16.
    rise_at = -1; tick_at = -1;
    btn_run = 1;
    for (int e = 0; e < 40; e++) begin
      cycle();
      if (e == 19) btn_run = 0;
      if (running === 1'b1 && rise_at < 0) rise_at = e;
      if (tick === 1'b1 && tick_at < 0) tick_at = e;
    end
    chk("run_latency", rise_at, 2 + DB_CYCLES + 1);
    chk("first_tick", tick_at, 2 + DB_CYCLES + 1 + DIV);

    // Raise fast when the prescaler sits at 7.
    for (int i = 0; i < 30 && m_phase != 7; i++) cycle();
    chk("phase7_reached", m_phase, 7);
    fast = 1;
    cycle();
    chk("fast_tick", tick, 1);
    cycles(13);
    fast = 0;
    cycles(25);

    // Pause again.
    press_run(6);
    chk("paused", running, 0);

    if (STEP_EN) begin
      // Step while paused: exactly one tick.
      cnt_ticks = 0;
      btn_step = 1;
      for (int i = 0; i < 20; i++) begin
        cycle();
        if (i == 7) btn_step = 0;
        if (tick === 1'b1) cnt_ticks++;
      end
      chk("step_ticks", cnt_ticks, 1);
      // RUN and STEP together while paused: run, no extra tick.
      cnt_ticks = 0;
      btn_run = 1; btn_step = 1;
      for (int i = 0; i < 2 + DB_CYCLES + 3; i++) begin
        cycle();
        if (tick === 1'b1) cnt_ticks++;
      end
      btn_run = 0; btn_step = 0;
      chk("both_no_tick", cnt_ticks, 0);
      chk("both_running", running, 1);
      // Step pressed while running.
      btn_step = 1;
      cycles(8);
      btn_step = 0;
      cycles(20);
      press_run(6);
    end

    // Randomized button and fast activity.
    for (int seg = 0; seg < 300; seg++) begin
      btn_run = 1'($urandom_range(0, 1));
      if (STEP_EN) btn_step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) fast = ~fast;
      dur = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
      cycles(dur);
    end
    btn_run = 0; btn_step = 0; fast = 0;
    cycles(10);

    // Asynchronous reset while a tick is high and a press is debouncing.
    if (!m_run) press_run(6);
    got_tick = 0;
    for (int i = 0; i < 30 && !got_tick; i++) begin
      cycle();
      if (tick === 1'b1) got_tick = 1;
    end
    chk("tick_before_reset", got_tick, 1);
    btn_run = 1;
    #2 reset_n = 0;
    #1;
    chk("async_rst_tick", tick, 0);
    chk("async_rst_running", running, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    btn_run = 0;
    reset_n = 1;
    cnt_ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (tick === 1'b1) cnt_ticks++;
    end
    chk("post_reset_ticks", cnt_ticks, 0);
    chk("post_reset_running", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
